// File: rtl/dram_arbiter.sv
// Two-requester arbiter for the CPU-side DRAM FIFO port, with an in-order tag FIFO that routes read responses.
// Define DRAM_ARB_ROUND_ROBIN_EN for round-robin grants; the default build uses fixed priority (requester 0 first).
module dram_arbiter #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 128,
    parameter int OUTSTANDING = 4
) (
    input  logic              sys_clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    input  logic              r0_rready,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    input  logic              r1_rready,

    output logic [DATA_W-1:0] r_rdata,

    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,

    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_rdata,

    output logic              orphan_err
);

    localparam int IDX_W = $clog2(OUTSTANDING);
    localparam int PTR_W = IDX_W + 1;

    // Handshake: a transfer happens on any rising edge where valid and ready are both high.

    logic              req_valid_q, req_valid_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              last_q, last_d;
    logic              orphan_q, orphan_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              tag_q [OUTSTANDING];

    logic fifo_full, fifo_empty, head_tag;
    logic elig0, elig1, gnt0, gnt1;
    logic slot_free, accept, sel, sel_we, push, pop;

    // Extra pointer MSB separates full from empty once the write pointer has wrapped.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign head_tag   = tag_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        elig0 = r0_valid && (r0_we || !fifo_full);
        elig1 = r1_valid && (r1_we || !fifo_full);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        if (elig0 && elig1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
`else
        gnt0 = elig0;
        gnt1 = elig1 && !elig0;
`endif
    end

    assign slot_free = !req_valid_q || req_ready;
    assign r0_ready  = gnt0 && slot_free;
    assign r1_ready  = gnt1 && slot_free;
    assign accept    = r0_ready || r1_ready;
    assign sel       = r1_ready;
    assign sel_we    = sel ? r1_we : r0_we;
    assign push      = accept && !sel_we;

    // With no read outstanding the port swallows stray words so dram_buf never blocks.
    always_comb begin
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        rsp_ready = 1'b1;
        if (!fifo_empty) begin
            r0_rvalid = rsp_valid && !head_tag;
            r1_rvalid = rsp_valid && head_tag;
            rsp_ready = head_tag ? r1_rready : r0_rready;
        end
    end

    assign pop     = !fifo_empty && rsp_valid && rsp_ready;
    assign r_rdata = rsp_rdata;

    always_comb begin
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        last_d      = last_q;
        orphan_d    = orphan_q || (fifo_empty && rsp_valid);
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        if (accept) begin
            req_valid_d = 1'b1;
            req_we_d    = sel_we;
            req_addr_d  = sel ? r1_addr : r0_addr;
            req_wdata_d = sel ? r1_wdata : r0_wdata;
            last_d      = sel;
        end else if (req_ready) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            last_q      <= 1'b1;
            orphan_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            last_q      <= last_d;
            orphan_q    <= orphan_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Tag storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            tag_q[wr_ptr_q[IDX_W-1:0]] <= sel;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_we     = req_we_q;
    assign req_addr   = req_addr_q;
    assign req_wdata  = req_wdata_q;
    assign orphan_err = orphan_q;

endmodule
